// File: rtl/onehot_decoder_pkg.sv
// onehot_decoder_stream shared types, defaults and decode helper.
// dec() works at a fixed maximum width; callers size-cast to OUT_W.
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 2;
  localparam int CNT_W_DEF = 8;

  localparam int DEC_IN_W  = 8;
  localparam int DEC_OUT_W = 1 << DEC_IN_W;

  function automatic logic [DEC_OUT_W-1:0] dec(
    input logic [DEC_IN_W-1:0] code
  );
    dec       = '0;
    dec[code] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_decoder_stream.sv
// Streaming binary-to-one-hot decoder with 2-entry skid buffer.
// Ports: clk, rst_n, in_code/in_valid/in_ready, out_onehot/out_valid/out_ready, xfer_count.
module onehot_decoder_stream
  import onehot_decoder_pkg::*;
#(
  parameter  int IN_W  = IN_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  state_t state_q, state_d;

  logic [OUT_W-1:0] oreg_q, oreg_d;
  logic [OUT_W-1:0] sreg_q, sreg_d;
  logic [OUT_W-1:0] dec_w;
  logic [CNT_W-1:0] cnt_q;
  logic             acc;
  logic             fire;

  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign out_onehot = oreg_q;
  assign xfer_count = cnt_q;

  assign acc  = in_valid & in_ready;
  assign fire = out_valid & out_ready;

  assign dec_w = OUT_W'(dec(DEC_IN_W'(in_code)));

  always_comb begin
    state_d = state_q;
    oreg_d  = oreg_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          oreg_d  = dec_w;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc && fire) begin
          oreg_d = dec_w;
        end else if (acc) begin
          sreg_d  = dec_w;
          state_d = FULL;
        end else if (fire) begin
          oreg_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (fire) begin
          oreg_d  = sreg_q;
          state_d = BUSY;
        end
      end
      default: begin
        oreg_d  = '0;
        sreg_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      oreg_q  <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      oreg_q  <= oreg_d;
      sreg_q  <= sreg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed self-checking bench for onehot_decoder_stream.
// A second instance with CNT_W=3 shares stimulus to cover saturation.
module tb_onehot_decoder_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_code;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic [7:0] xfer_count;

  logic       s_in_ready;
  logic [3:0] s_out_onehot;
  logic       s_out_valid;
  logic [2:0] s_xfer_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  onehot_decoder_stream #(.IN_W(2), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  onehot_decoder_stream #(.IN_W(2), .CNT_W(3)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .out_onehot (s_out_onehot),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .xfer_count (s_xfer_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_code   = 2'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_onehot", 8'(out_onehot), 8'h0);
    chk("rst_count", xfer_count, 8'd0);

    // full-rate decode
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code = 2'd0; step();
    chk("fr_oh0", 8'(out_onehot), 8'h1);
    chk("fr_v0", 8'(out_valid), 8'd1);
    in_code = 2'd1; step();
    chk("fr_oh1", 8'(out_onehot), 8'h2);
    chk("fr_v1", 8'(out_valid), 8'd1);
    in_code = 2'd2; step();
    chk("fr_oh2", 8'(out_onehot), 8'h4);
    in_code = 2'd3; step();
    chk("fr_oh3", 8'(out_onehot), 8'h8);
    chk("fr_v3", 8'(out_valid), 8'd1);
    in_valid = 1'b0; step();
    chk("fr_count", xfer_count, 8'd4);
    chk("fr_idle_v", 8'(out_valid), 8'd0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code = 2'd2; step();
    chk("bp_oh_a", 8'(out_onehot), 8'h4);
    in_code = 2'd3; step();
    chk("bp_oh_b", 8'(out_onehot), 8'h4);
    chk("bp_rdy_b", 8'(in_ready), 8'd0);
    in_code = 2'd1; step();
    chk("bp_oh_c", 8'(out_onehot), 8'h4);
    chk("bp_rdy_c", 8'(in_ready), 8'd0);
    chk("bp_cnt_c", xfer_count, 8'd4);
    out_ready = 1'b1; step();
    chk("bp_oh_d", 8'(out_onehot), 8'h8);
    chk("bp_rdy_d", 8'(in_ready), 8'd1);
    step();
    chk("bp_oh_e", 8'(out_onehot), 8'h2);
    in_valid = 1'b0; step();
    chk("bp_v_f", 8'(out_valid), 8'd0);
    chk("bp_cnt_f", xfer_count, 8'd7);

    // drain
    in_valid = 1'b1;
    in_code  = 2'd3; step();
    chk("dr_oh", 8'(out_onehot), 8'h8);
    in_valid = 1'b0; step();
    chk("dr_v", 8'(out_valid), 8'd0);
    chk("dr_oh0", 8'(out_onehot), 8'h0);
    chk("dr_cnt", xfer_count, 8'd8);
    chk("sat_pre", 8'(s_xfer_count), 8'd7);

    // async reset from FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code = 2'd0; step();
    in_code = 2'd1; step();
    chk("ar_full", 8'(in_ready), 8'd0);
    chk("ar_oh", 8'(out_onehot), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rdy", 8'(in_ready), 8'd1);
    chk("ar_v", 8'(out_valid), 8'd0);
    chk("ar_oh0", 8'(out_onehot), 8'h0);
    chk("ar_cnt", xfer_count, 8'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code = 2'd2; step();
    chk("ar_first_oh", 8'(out_onehot), 8'h4);
    chk("ar_first_cnt", xfer_count, 8'd0);

    // saturation: 10 transfers in total
    for (int i = 0; i < 9; i++) begin
      in_code = 2'(i);
      step();
      chk("sat_oh", 8'(out_onehot), 8'(4'b0001 << (i % 4)));
    end
    in_valid = 1'b0; step();
    chk("sat_cnt", 8'(s_xfer_count), 8'd7);
    chk("sat_main", xfer_count, 8'd10);
    step();
    chk("sat_hold", 8'(s_xfer_count), 8'd7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_stream.md
# onehot_decoder_stream

- Streaming binary-to-one-hot decoder: the inverse of the team's 4-to-2 encoder.
- Accepts an IN_W-bit code over a valid/ready handshake and presents the registered one-hot word over a second valid/ready handshake.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Sits between the encoder-driven select path and the downstream one-hot consumers; also keeps a saturating count of delivered words.

## Interface
- IN_W, 2: input code width; output width is OUT_W = 2**IN_W (default 4).
- CNT_W, 8: width of the delivered-word counter.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_code  input  IN_W  binary code to decode.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept in_code this cycle.
- out_onehot  output  OUT_W  decoded word; bit k set iff code == k.
- out_valid  output  1  out_onehot is valid.
- out_ready  input  1  downstream accepts out_onehot this cycle.
- xfer_count  output  CNT_W  number of output transfers since reset, saturating.

## Operation
- Input accept (acc) = in_valid & in_ready. Output fire (fire) = out_valid & out_ready.
- Every IN_W-bit code is legal. Decode is out_onehot = 1 << in_code, performed on entry into storage.
- Storage is an output register (OREG) plus a skid register (SREG).
- State machine, registered:
  - EMPTY: nothing held.
  - BUSY: OREG valid, SREG empty.
  - FULL: OREG and SREG both valid.
- Transitions:
  - EMPTY, acc: OREG <= dec(in_code); go to BUSY.
  - BUSY, acc & fire: OREG <= dec(in_code); stay in BUSY.
  - BUSY, acc & !fire: SREG <= dec(in_code); go to FULL.
  - BUSY, !acc & fire: OREG <= 0; go to EMPTY.
  - FULL, fire: OREG <= SREG; go to BUSY.
  - All other cases: hold.
- Decoded outputs:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - Both come straight from the state register, with no combinational path from in_valid or out_ready.
- out_onehot is 0 whenever out_valid is 0. Holding OREG while out_valid=1 & !out_ready is mandatory; out_onehot must not change until fire.
- xfer_count increments by 1 on each fire and saturates at 2**CNT_W-1, with no wrap-around.
- Ordering is strict FIFO: words leave in acceptance order, with none dropped or duplicated.

## Timing
- Reset values: state=EMPTY, in_ready=1, out_valid=0, out_onehot=0, xfer_count=0. SREG is cleared to 0.
- Asserting rst_n low mid-operation discards OREG and SREG contents immediately, without waiting for a clock edge. The first accept after release behaves as from EMPTY.
- Latency: a code accepted at edge N appears on out_valid/out_onehot after edge N, i.e. one cycle.
- Throughput: one word per cycle when out_ready is held high.
- Backpressure: after out_ready drops, at most one further word is accepted (into SREG). in_ready falls in the cycle after that accept.
- In FULL, fire at edge N raises in_ready after edge N. A new accept is possible at edge N+1.
- If acc and fire coincide in EMPTY, there is no fire, since out_valid=0.
- xfer_count updates on the same edge as the fire it counts.

## Structure
- Package onehot_decoder_pkg holds:
  - the state typedef (EMPTY/BUSY/FULL, 2-bit);
  - the default IN_W and CNT_W constants;
  - the decode function dec(code) returning the OUT_W-bit one-hot word.
- Single module. No sub-module is needed; the skid logic is small and bound to the state machine.

## Test plan
- Reset: hold rst_n=0 then release. Check in_ready=1, out_valid=0, out_onehot=4'b0000, xfer_count=0.
- Full-rate decode: out_ready=1; feed codes 0,1,2,3 on consecutive cycles. Expect out_onehot 0001, 0010, 0100, 1000 one cycle later each, out_valid continuously high, and xfer_count=4.
- Backpressure: drop out_ready while streaming codes 2,3,1.
  - Expect OREG held at 0100.
  - Code 3 (1000) captured in SREG.
  - in_ready low the next cycle, and code 1 not accepted.
  - Raise out_ready: expect order 0100, 1000, 0010 with no loss.
- Drain: single code 3, then in_valid=0. Expect out_onehot=1000 for one fire, then out_valid=0 and out_onehot=0000.
- Async reset mid-operation: reach FULL, assert rst_n between edges. Expect all outputs at reset values before the next edge.
- Counter saturation: CNT_W=3; perform 10 transfers. Expect xfer_count to reach 7 and stay at 7.
